// File: rtl/merge_rr_arb32_pkg.sv
// Shared constants and types for the 32-way round-robin merge arbiter.
// Optional feature macro used by this slice: MERGE_ARB_COUNT_EN (transfer counter).
package merge_arb_pkg;

    localparam int N_REQ      = 32;
    localparam int IDX_W      = 5;
    localparam int XFER_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/merge_rr_arb32_if.sv
// Bundle of request/acknowledge and downstream valid/ready signals of the merge arbiter.
// The master modport is the arbiter side; the slave modport is the requester/downstream side.
// With MERGE_ARB_COUNT_EN defined the bundle also carries the completed-transfer count.
interface merge_rr_arb32_if #(
    parameter int DATA_WIDTH = 32
);
    import merge_arb_pkg::*;

    logic [N_REQ-1:0]            i_req;
    logic [N_REQ*DATA_WIDTH-1:0] i_data;
    logic [N_REQ-1:0]            o_free;
    logic [N_REQ-1:0]            o_grant;
    logic [IDX_W-1:0]            o_grant_idx;
    logic                        o_valid;
    logic                        i_ready;
    logic [DATA_WIDTH-1:0]       o_data;
`ifdef MERGE_ARB_COUNT_EN
    logic [XFER_CNT_W-1:0]       o_xfer_cnt;

    modport master (
        input  i_req, i_data, i_ready,
        output o_free, o_grant, o_grant_idx, o_valid, o_data, o_xfer_cnt
    );

    modport slave (
        output i_req, i_data, i_ready,
        input  o_free, o_grant, o_grant_idx, o_valid, o_data, o_xfer_cnt
    );
`else
    modport master (
        input  i_req, i_data, i_ready,
        output o_free, o_grant, o_grant_idx, o_valid, o_data
    );

    modport slave (
        output i_req, i_data, i_ready,
        input  o_free, o_grant, o_grant_idx, o_valid, o_data
    );
`endif

endinterface

// File: rtl/merge_rr_arb32_pick.sv
// Combinational round-robin picker: finds the first request at or above ptr,
// wrapping from 31 to 0, by searching a doubled copy of the request vector.
module rr_pick32
    import merge_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [IDX_W-1:0]   offset;

    assign doubled = {req, req};
    assign rotated = N_REQ'(doubled >> ptr);

    // Lowest set bit of the rotated window is the distance from ptr to the winner
    always_comb begin
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDX_W'(i);
            end
        end
    end

    assign any   = |req;
    assign idx   = ptr + offset;
    assign grant = any ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/merge_rr_arb32.sv
// 32-way round-robin arbiter and data merge. One requester at a time is granted,
// its data registered and offered downstream on valid/ready, then acknowledged
// with a return-to-zero free pulse. All outputs come straight from registers.
// Optional: define MERGE_ARB_COUNT_EN to add the 16-bit completed-transfer counter.
module merge_rr_arb32
    import merge_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    merge_rr_arb32_if.master bus
);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic [N_REQ-1:0]      free_q, free_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [N_REQ-1:0]      pick_grant;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [DATA_WIDTH-1:0] win_data;

    rr_pick32 u_pick (
        .req   (bus.i_req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign win_data = bus.i_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];

    // Next-state and next-output decisions for the grant/send/release sequence
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        free_d  = free_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    data_d  = win_data;
                    grant_d = pick_grant;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (valid_q && bus.i_ready) begin
                    valid_d = 1'b0;
                    free_d  = grant_q;
                    ptr_d   = idx_q + IDX_W'(1);
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.i_req[idx_q]) begin
                    free_d  = '0;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and output registers; reset discards any transfer in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            free_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            free_q  <= free_d;
            data_q  <= data_d;
        end
    end

    assign bus.o_free      = free_q;
    assign bus.o_grant     = grant_q;
    assign bus.o_grant_idx = idx_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_data      = data_q;

`ifdef MERGE_ARB_COUNT_EN
    logic [XFER_CNT_W-1:0] xfer_cnt_q;

    // Count every downstream handshake, wrapping naturally at the counter width
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else if (valid_q && bus.i_ready) begin
            xfer_cnt_q <= xfer_cnt_q + 1'b1;
        end
    end

    assign bus.o_xfer_cnt = xfer_cnt_q;
`endif

endmodule
